smart_mac_multi: RTL and testbench

SMART_MAC_MULTI -- requirements
Module: smart_mac_multi

---
 rtl/smart_mac_multi.sv | 211 +++++++++++++++++++++
 tb/tb_smart_mac_multi.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/smart_mac_multi.sv
// smart_mac_multi: memory access controller for several protected code/key regions.
// Code in region r may only be entered at CODE_LOW[r] and left from CODE_HIGH[r].
// Key region k may only be read while region k is executing. A violation raises
// sys_reset for RESET_PULSE cycles and records a sticky cause code.
//
// Ports
//   mclk          clock, rising edge
//   puc_rst       synchronous active-high reset
//   ins_valid     ins_addr holds a newly fetched instruction address
//   ins_addr      instruction fetch address
//   mem_rd        data read strobe for mem_addr
//   mem_addr      data access address
//   mem_din       read data from memory
//   dbg_active    debug interface attached
//   mem_dout      read data to CPU (zero for a blocked key read)
//   in_safe_area  high while executing inside a protected region
//   region_id     index of the executing region, 0 outside
//   sys_reset     registered system reset request
//   viol_cause    sticky cause of last violation
//                 (1 key read, 2 illegal entry, 3 illegal exit, 4 debug)
//
// state  | meaning
// IDLE   | executing unprotected code
// INSIDE | executing code of region region_id
// VIOL   | reset pulse in progress, inputs other than puc_rst ignored

module smart_mac_multi #(
  parameter int SIZE_MEM_ADDR = 16,
  parameter int NUM_REGIONS   = 2,
  parameter int RESET_PULSE   = 4,
  parameter logic [NUM_REGIONS*SIZE_MEM_ADDR-1:0] CODE_LOW  = {16'd64,  16'd16},
  parameter logic [NUM_REGIONS*SIZE_MEM_ADDR-1:0] CODE_HIGH = {16'd95,  16'd32},
  parameter logic [NUM_REGIONS*SIZE_MEM_ADDR-1:0] KEY_LOW   = {16'd100, 16'd40},
  parameter logic [NUM_REGIONS*SIZE_MEM_ADDR-1:0] KEY_HIGH  = {16'd107, 16'd47},
  localparam int RID_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                     mclk,
  input  logic                     puc_rst,
  input  logic                     ins_valid,
  input  logic [SIZE_MEM_ADDR-1:0] ins_addr,
  input  logic                     mem_rd,
  input  logic [SIZE_MEM_ADDR-1:0] mem_addr,
  input  logic [15:0]              mem_din,
  input  logic                     dbg_active,
  output logic [15:0]              mem_dout,
  output logic                     in_safe_area,
  output logic [RID_W-1:0]         region_id,
  output logic                     sys_reset,
  output logic [2:0]               viol_cause
);

  localparam int CW = $clog2(RESET_PULSE + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] INSIDE = 2'd1;
  localparam logic [1:0] VIOL   = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [RID_W-1:0]         rid_q, rid_d;
  logic [SIZE_MEM_ADDR-1:0] prev_q, prev_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2:0]               cause_q, cause_d;
  logic                     sysrst_q, sysrst_d;

  logic                     code_hit, code_entry;
  logic [RID_W-1:0]         code_rid;
  logic                     key_hit;
  logic [RID_W-1:0]         key_rid;
  logic                     cur_in_code;
  logic [SIZE_MEM_ADDR-1:0] cur_high;
  logic                     key_block;
  logic                     v1, v2, v3, v4;
  logic [2:0]               viol_code;

  // Region matching; loops run downward so the lowest index wins on overlap.
  always_comb begin
    code_hit    = 1'b0;
    code_entry  = 1'b0;
    code_rid    = '0;
    key_hit     = 1'b0;
    key_rid     = '0;
    cur_in_code = 1'b0;
    cur_high    = '0;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if (ins_addr >= CODE_LOW[r*SIZE_MEM_ADDR +: SIZE_MEM_ADDR] &&
          ins_addr <= CODE_HIGH[r*SIZE_MEM_ADDR +: SIZE_MEM_ADDR]) begin
        code_hit   = 1'b1;
        code_rid   = RID_W'(r);
        code_entry = (ins_addr == CODE_LOW[r*SIZE_MEM_ADDR +: SIZE_MEM_ADDR]);
      end
      if (mem_addr >= KEY_LOW[r*SIZE_MEM_ADDR +: SIZE_MEM_ADDR] &&
          mem_addr <= KEY_HIGH[r*SIZE_MEM_ADDR +: SIZE_MEM_ADDR]) begin
        key_hit = 1'b1;
        key_rid = RID_W'(r);
      end
      if (rid_q == RID_W'(r)) begin
        cur_high    = CODE_HIGH[r*SIZE_MEM_ADDR +: SIZE_MEM_ADDR];
        cur_in_code = ins_addr >= CODE_LOW[r*SIZE_MEM_ADDR +: SIZE_MEM_ADDR] &&
                      ins_addr <= CODE_HIGH[r*SIZE_MEM_ADDR +: SIZE_MEM_ADDR];
      end
    end
  end

  // Key reads are only allowed from the owning region; this also masks reads during VIOL.
  assign key_block = mem_rd && key_hit && !(state_q == INSIDE && rid_q == key_rid);
  assign mem_dout  = key_block ? 16'h0000 : mem_din;

  always_comb begin
    state_d  = state_q;
    rid_d    = rid_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    sysrst_d = sysrst_q;
    v1 = 1'b0;
    v2 = 1'b0;
    v3 = 1'b0;
    v4 = 1'b0;
    viol_code = 3'd0;

    case (state_q)
      IDLE: begin
        v1 = key_block;
        if (ins_valid) begin
          prev_d = ins_addr;
          if (code_hit) begin
            if (code_entry) begin
              state_d = INSIDE;
              rid_d   = code_rid;
            end else begin
              v2 = 1'b1;
            end
          end
        end
      end
      INSIDE: begin
        v1 = key_block;
        v4 = dbg_active;
        if (ins_valid) begin
          prev_d = ins_addr;
          if (!cur_in_code) begin
            if (prev_q == cur_high) begin
              // Legal exit: the new address is judged as if fetched from IDLE.
              if (code_hit && code_entry) begin
                rid_d = code_rid;
              end else if (code_hit) begin
                v2 = 1'b1;
              end else begin
                state_d = IDLE;
                rid_d   = '0;
              end
            end else begin
              v3 = 1'b1;
            end
          end
        end
      end
      VIOL: begin
        if (cnt_q == '0) begin
          state_d  = IDLE;
          sysrst_d = 1'b0;
          rid_d    = '0;
          prev_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rid_d   = '0;
      end
    endcase

    if (v4) viol_code = 3'd4;
    if (v3) viol_code = 3'd3;
    if (v2) viol_code = 3'd2;
    if (v1) viol_code = 3'd1;

    if (viol_code != 3'd0) begin
      state_d  = VIOL;
      rid_d    = '0;
      cause_d  = viol_code;
      sysrst_d = 1'b1;
      cnt_d    = CW'(RESET_PULSE - 1);
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q  <= IDLE;
      rid_q    <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      cause_q  <= 3'd0;
      sysrst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rid_q    <= rid_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      sysrst_q <= sysrst_d;
    end
  end

  assign in_safe_area = (state_q == INSIDE);
  assign region_id    = rid_q;
  assign sys_reset    = sysrst_q;
  assign viol_cause   = cause_q;

endmodule

// File: tb/tb_smart_mac_multi.sv
module tb_smart_mac_multi;

  localparam int P = 4;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        ins_valid;
  logic [15:0] ins_addr;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic        dbg_active;
  logic [15:0] mem_dout;
  logic        in_safe_area;
  logic [0:0]  region_id;
  logic        sys_reset;
  logic [2:0]  viol_cause;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  smart_mac_multi #(
    .SIZE_MEM_ADDR(16),
    .NUM_REGIONS(2),
    .RESET_PULSE(P),
    .CODE_LOW ({16'd64,  16'd16}),
    .CODE_HIGH({16'd95,  16'd32}),
    .KEY_LOW  ({16'd100, 16'd40}),
    .KEY_HIGH ({16'd107, 16'd47})
  ) dut (
    .mclk(mclk),
    .puc_rst(puc_rst),
    .ins_valid(ins_valid),
    .ins_addr(ins_addr),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .dbg_active(dbg_active),
    .mem_dout(mem_dout),
    .in_safe_area(in_safe_area),
    .region_id(region_id),
    .sys_reset(sys_reset),
    .viol_cause(viol_cause)
  );

  always #5 mclk = ~mclk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] v);
    push_exp(tag, v);
    pop_cmp(obs);
  endtask

  task automatic ins(input logic [15:0] a);
    ins_valid = 1'b1;
    ins_addr  = a;
    tick();
    ins_valid = 1'b0;
  endtask

  task automatic pulse(input string tag);
    for (int i = 0; i < P; i++) begin
      chk({tag, "_hi"}, 32'(sys_reset), 32'd1);
      tick();
    end
    chk({tag, "_lo"}, 32'(sys_reset), 32'd0);
    chk({tag, "_safe"}, 32'(in_safe_area), 32'd0);
    chk({tag, "_rid"}, 32'(region_id), 32'd0);
  endtask

  initial begin
    puc_rst = 1'b1; ins_valid = 1'b0; ins_addr = '0; mem_rd = 1'b0;
    mem_addr = '0; mem_din = 16'h1234; dbg_active = 1'b0;
    tick(); tick();
    puc_rst = 1'b0;
    chk("rst_safe",  32'(in_safe_area), 32'd0);
    chk("rst_rid",   32'(region_id),    32'd0);
    chk("rst_sys",   32'(sys_reset),    32'd0);
    chk("rst_cause", 32'(viol_cause),   32'd0);
    #1 chk("rst_dout", 32'(mem_dout), 32'h1234);

    // Enter region 0, legal key read
    ins(16'd16);
    chk("enter0_safe", 32'(in_safe_area), 32'd1);
    chk("enter0_rid",  32'(region_id),    32'd0);
    mem_rd = 1'b1; mem_addr = 16'd42; mem_din = 16'hA5A5;
    #1 chk("key0_read", 32'(mem_dout), 32'hA5A5);
    tick();
    mem_rd = 1'b0;
    chk("key0_sys", 32'(sys_reset), 32'd0);

    // Walk to region end, hand off directly to region 1 entry
    ins(16'd17);
    ins(16'd32);
    ins(16'd64);
    chk("hand_rid",   32'(region_id),    32'd1);
    chk("hand_safe",  32'(in_safe_area), 32'd1);
    chk("hand_sys",   32'(sys_reset),    32'd0);
    chk("hand_cause", 32'(viol_cause),   32'd0);
    ins(16'd70);
    ins(16'd5);
    chk("exit3_cause", 32'(viol_cause), 32'd3);
    pulse("exit3");
    chk("exit3_sticky", 32'(viol_cause), 32'd3);

    // Key read from IDLE
    mem_rd = 1'b1; mem_addr = 16'd44; mem_din = 16'hFFFF;
    #1 chk("key_idle_mask", 32'(mem_dout), 32'h0);
    tick();
    mem_rd = 1'b0;
    chk("key_idle_cause", 32'(viol_cause), 32'd1);
    pulse("key_idle");

    // Illegal mid-region entry
    ins(16'd20);
    chk("entry2_cause", 32'(viol_cause), 32'd2);
    pulse("entry2");
    chk("entry2_sticky", 32'(viol_cause), 32'd2);

    // Legal exit from region 1 at its last address back to unprotected code
    ins(16'd64);
    mem_rd = 1'b1; mem_addr = 16'd107; mem_din = 16'h5A5A;
    #1 chk("key1_read", 32'(mem_dout), 32'h5A5A);
    mem_addr = 16'd39;
    #1 chk("nonkey_read", 32'(mem_dout), 32'h5A5A);
    mem_rd = 1'b0;
    ins(16'd95);
    ins(16'd200);
    chk("exit_ok_safe",  32'(in_safe_area), 32'd0);
    chk("exit_ok_sys",   32'(sys_reset),    32'd0);
    chk("exit_ok_cause", 32'(viol_cause),   32'd2);

    // Debug plus illegal key read in region 1: lowest cause wins
    ins(16'd64);
    dbg_active = 1'b1; mem_rd = 1'b1; mem_addr = 16'd41; mem_din = 16'hBEEF;
    #1 chk("dbg_key_mask", 32'(mem_dout), 32'h0);
    tick();
    dbg_active = 1'b0; mem_rd = 1'b0;
    chk("prio_cause", 32'(viol_cause), 32'd1);
    chk("prio_sys1",  32'(sys_reset),  32'd1);
    tick();
    chk("prio_sys2",  32'(sys_reset),  32'd1);
    puc_rst = 1'b1;
    tick();
    puc_rst = 1'b0;
    chk("abort_sys",   32'(sys_reset),    32'd0);
    chk("abort_cause", 32'(viol_cause),   32'd0);
    chk("abort_safe",  32'(in_safe_area), 32'd0);

    // Debug alone inside region 0
    ins(16'd16);
    dbg_active = 1'b1;
    tick();
    dbg_active = 1'b0;
    chk("dbg_cause", 32'(viol_cause), 32'd4);
    pulse("dbg");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
